uart_rx_core: RTL and testbench

Synthesizable UART receiver that sits on the FIR design's serial input line, directly downstream of the host UART (the bench's UART model in simulation). Recovers 8N1 frames from the asynchronous `rx_in` line and presents each byte to the FIR input stage over a valid/ready handshake. Also flags framing errors and overruns.

---
 rtl/uart_rx_core.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with mid-bit sampling, a one-byte holding
// register behind a valid/ready handshake, and framing-error / overrun pulses.
module uart_rx_core #(
  parameter int G_CLK_FREQ = 100000000,
  parameter int G_BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Rounded clocks-per-bit and half-bit offset used to land on bit centres.
  localparam int C_DIV  = (G_CLK_FREQ + (G_BAUD / 2)) / G_BAUD;
  localparam int C_HALF = C_DIV / 2;
  localparam int CW     = $clog2(C_DIV);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(C_DIV - 1);
  localparam logic [CW-1:0] C_CNT_HALF = CW'(C_HALF - 1);
  localparam logic [CW-1:0] C_CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  // Fewer than 8 clocks per bit leaves no meaningful mid-bit sample point.
  if (C_DIV < 8) begin : g_div_check
    $error("uart_rx_core: clocks per bit must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic [1:0]    sync_r;
  logic          rx_s;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          load_s;
  logic          ferr_s;
  logic          ovr_s;
  logic          valid_s;

  // Two-flop synchronizer; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_in};
    end
  end

  assign rx_s = sync_r[1];

  // FSM, bit-timing counter, bit index and shift register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= C_CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
    end
  end

  // Next-state logic: sample at bit centres and decide what the frame yields.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    load_s  = 1'b0;
    ferr_s  = 1'b0;
    ovr_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_s = C_CNT_ZERO;
        idx_s = 3'd0;
        if (!rx_s) begin
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == C_CNT_HALF) begin
          cnt_s = C_CNT_ZERO;
          idx_s = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_s) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          cnt_s = cnt_r + C_CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == C_CNT_LAST) begin
          cnt_s   = C_CNT_ZERO;
          shift_s = {rx_s, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = S_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + C_CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_r == C_CNT_LAST) begin
          cnt_s = C_CNT_ZERO;
          if (rx_s) begin
            // Returning to IDLE mid stop bit lets back-to-back frames through.
            state_s = S_IDLE;
            if (!rx_valid || rx_ready) begin
              load_s = 1'b1;
            end else begin
              ovr_s = 1'b1;
            end
          end else begin
            ferr_s  = 1'b1;
            state_s = S_WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + C_CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        cnt_s = C_CNT_ZERO;
        // Holding here makes a break condition report only one frame error.
        if (rx_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_HIGH;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = C_CNT_ZERO;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Holding-register valid: a new load wins over a simultaneous handshake.
  always_comb begin
    if (load_s) begin
      valid_s = 1'b1;
    end else if (rx_valid && rx_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = rx_valid;
    end
  end

  // Registered outputs: holding register, status pulses and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data <= shift_r;
      end else begin
        rx_data <= rx_data;
      end
      rx_valid  <= valid_s;
      frame_err <= ferr_s;
      overrun   <= ovr_s;
      busy      <= (state_r != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed, table-driven bench for uart_rx_core using a
// small clock-per-bit setting (16 clk per bit) to keep frames short.
module tb_uart_rx_core;

  localparam int P_CLK  = 1600;
  localparam int P_BAUD = 100;
  localparam int DIV    = 16;
  localparam int HALF   = 8;
  localparam int LAT    = HALF + 9 * DIV + 3;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;

  uart_rx_core #(.G_CLK_FREQ(P_CLK), .G_BAUD(P_BAUD)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshakes, pulses, valid rises and hold violations.
  logic [7:0] hs_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = 0;
  int         hold_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) hs_q.push_back(rx_data);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (rx_valid && !prev_valid) rise_cyc <= cyc;
      if (prev_valid && !prev_hs && rx_valid && (rx_data !== prev_data)) begin
        hold_err <= hold_err + 1;
        $display("FAIL hold_stable: rx_data changed %02h -> %02h without handshake", prev_data, rx_data);
      end
    end
    prev_valid <= rx_valid;
    prev_hs    <= rx_valid && rx_ready;
    prev_data  <= rx_data;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  int start_cyc = 0;

  // Serialise one 8N1 frame; a low stop bit may be held for extra bit times.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int hold_bits);
    rx_in = 1'b0;
    start_cyc = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(DIV);
    end
    rx_in = stop;
    tick(DIV);
    if (!stop) begin
      tick(DIV * hold_bits);
      check("wait_high_busy", {31'd0, busy}, 32'd1);
    end
    rx_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_hs;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[9];
  int   base_hs;
  int   base_ferr;
  int   base_ovr;
  logic [7:0] stream_pat[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
    vecs[3] = '{8'h55, 1'b1, 0, 1, 8'h55, 0};
    vecs[4] = '{8'h3C, 1'b1, 0, 1, 8'h3C, 0};
    vecs[5] = '{8'h81, 1'b0, 2, 0, 8'h00, 1};
    vecs[6] = '{8'h7E, 1'b1, 0, 1, 8'h7E, 0};
    vecs[7] = '{8'h01, 1'b1, 0, 1, 8'h01, 0};
    vecs[8] = '{8'h80, 1'b1, 0, 1, 8'h80, 0};
    stream_pat = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'h55};
    checks = 0;
    errors = 0;

    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(DIV);

    // Table of single frames with rx_ready held high.
    for (int i = 0; i < 9; i++) begin
      base_hs   = hs_q.size();
      base_ferr = ferr_cnt;
      base_ovr  = ovr_cnt;
      send_byte(vecs[i].data, vecs[i].stop, vecs[i].hold);
      tick(2 * DIV);
      check("vec_handshakes", hs_q.size() - base_hs, vecs[i].exp_hs);
      if (vecs[i].exp_hs == 1 && hs_q.size() > base_hs)
        check("vec_data", {24'd0, hs_q[base_hs]}, {24'd0, vecs[i].exp_data});
      check("vec_frame_err", ferr_cnt - base_ferr, vecs[i].exp_ferr);
      check("vec_overrun", ovr_cnt - base_ovr, 32'd0);
      check("vec_idle_busy", {31'd0, busy}, 32'd0);
      if (i == 0) begin
        checks++;
        if ((rise_cyc - start_cyc) < LAT - 1 || (rise_cyc - start_cyc) > LAT + 1) begin
          errors++;
          $display("FAIL latency: got %0d clk required %0d+-1", rise_cyc - start_cyc, LAT);
        end
      end
    end

    // Back-to-back stream 0x00..0x1F.
    base_hs = hs_q.size();
    for (int b = 0; b < 32; b++) send_byte(8'(b), 1'b1, 0);
    tick(2 * DIV);
    check("stream_count", hs_q.size() - base_hs, 32'd32);
    for (int k = 0; k < 32; k++) begin
      if (base_hs + k < hs_q.size())
        check("stream_data", {24'd0, hs_q[base_hs + k]}, k);
    end

    // Back-to-back 0x00/0xFF/0x55 patterns.
    base_hs = hs_q.size();
    for (int b = 0; b < 6; b++) send_byte(stream_pat[b], 1'b1, 0);
    tick(2 * DIV);
    check("pattern_count", hs_q.size() - base_hs, 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (base_hs + k < hs_q.size())
        check("pattern_data", {24'd0, hs_q[base_hs + k]}, {24'd0, stream_pat[k]});
    end

    // Glitch shorter than half a bit is rejected.
    base_hs = hs_q.size();
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    tick(DIV);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", hs_q.size() - base_hs, 32'd0);
    send_byte(8'h3C, 1'b1, 0);
    tick(2 * DIV);
    check("glitch_next_count", hs_q.size() - base_hs, 32'd1);
    if (hs_q.size() > base_hs)
      check("glitch_next_data", {24'd0, hs_q[base_hs]}, 32'h3C);

    // Overrun: second byte dropped while the first is held.
    rx_ready  = 1'b0;
    base_hs   = hs_q.size();
    base_ovr  = ovr_cnt;
    base_ferr = ferr_cnt;
    send_byte(8'h11, 1'b1, 0);
    tick(DIV);
    send_byte(8'h22, 1'b1, 0);
    tick(2 * DIV);
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, rx_data}, 32'h11);
    check("ovr_pulse_count", ovr_cnt - base_ovr, 32'd1);
    check("ovr_no_handshake", hs_q.size() - base_hs, 32'd0);
    check("ovr_no_ferr", ferr_cnt - base_ferr, 32'd0);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_valid_fall", {31'd0, rx_valid}, 32'd0);
    check("ovr_accept_count", hs_q.size() - base_hs, 32'd1);
    if (hs_q.size() > base_hs)
      check("ovr_accept_data", {24'd0, hs_q[base_hs]}, 32'h11);

    // Reset during data bit 4 of 0xF0.
    rx_in = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      tick(DIV);
    end
    rx_in = 1'b1;
    tick(HALF);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(2 * DIV);
    base_hs   = hs_q.size();
    base_ferr = ferr_cnt;
    send_byte(8'h0F, 1'b1, 0);
    tick(2 * DIV);
    check("post_rst_count", hs_q.size() - base_hs, 32'd1);
    if (hs_q.size() > base_hs)
      check("post_rst_data", {24'd0, hs_q[base_hs]}, 32'h0F);
    check("post_rst_ferr", ferr_cnt - base_ferr, 32'd0);

    check("hold_violations", hold_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
